// File: rtl/fmap_buf_pkg.sv
// Shared types for the ping-pong feature-map buffer: bank states and the debug
// view of the controller state.
package fmap_buf_pkg;

  localparam int NUM_BANKS = 2;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_t;

  typedef struct packed {
    bank_state_t bank1_state;
    bank_state_t bank0_state;
    logic        wr_bank;
    logic        rd_bank;
  } fmap_dbg_t;

endpackage

// File: rtl/com_dual_port_ram.sv
// Dual-port RAM with a registered read on each port (read-before-write).
// Both ports share one clock.
module com_dual_port_ram #(
  parameter int WIDTH         = 4,
  parameter int ADDR_BIT      = 10,
  parameter int DEPTH         = 1024,
  parameter     RAM_STYLE_VAL = "block"
) (
  input  logic                clk,
  input  logic                en_a,
  input  logic                we_a,
  input  logic [ADDR_BIT-1:0] addr_a,
  input  logic [WIDTH-1:0]    di_a,
  output logic [WIDTH-1:0]    dout_a,
  input  logic                en_b,
  input  logic                we_b,
  input  logic [ADDR_BIT-1:0] addr_b,
  input  logic [WIDTH-1:0]    di_b,
  output logic [WIDTH-1:0]    dout_b
);

  (* ram_style = RAM_STYLE_VAL *) logic [WIDTH-1:0] mem [DEPTH];

  // Single process owns the array; port B wins a same-address write collision.
  always_ff @(posedge clk) begin
    if (en_a) begin
      dout_a <= mem[addr_a];
      if (we_a) mem[addr_a] <= di_a;
    end
    if (en_b) begin
      dout_b <= mem[addr_b];
      if (we_b) mem[addr_b] <= di_b;
    end
  end

endmodule

// File: rtl/fmap_buf_ctrl.sv
// Ping-pong feature-map buffer controller: one dual-port RAM split into two
// banks, producer fills via port A, consumer reads a FULL bank via port B.
// Optional sticky error flags are built when FMAP_BUF_ERR_EN is defined.
//
// Handshakes: a write moves on a cycle with wr_valid & wr_ready, a read on
// rd_req & rd_avail; both ready-type signals depend only on registered state.
module fmap_buf_ctrl
  import fmap_buf_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int ADDR_BIT      = 10,
  parameter int DEPTH         = 1024,
  parameter int FRAME_LEN     = 512,
  parameter     RAM_STYLE_VAL = "block"
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_req,
  input  logic [ADDR_BIT-2:0]   rd_addr,
  output logic                  rd_avail,
  output logic                  rd_data_valid,
  output logic [WIDTH-1:0]      rd_data,
  input  logic                  rd_release,
  output logic [NUM_BANKS-1:0]  bank_full,
  output logic [1:0]            err,
  output fmap_dbg_t             dbg
);

  localparam logic [ADDR_BIT-2:0] CNT_LAST = (ADDR_BIT-1)'(FRAME_LEN - 1);
  localparam logic [ADDR_BIT-2:0] CNT_ONE  = (ADDR_BIT-1)'(1);

  bank_state_t         state_q [NUM_BANKS];
  bank_state_t         state_d [NUM_BANKS];
  logic                wr_bank_q, wr_bank_d;
  logic                rd_bank_q, rd_bank_d;
  logic [ADDR_BIT-2:0] wr_cnt_q, wr_cnt_d;
  logic                wr_acc, rd_acc, rd_rel;
  logic                rd_pend;
  logic [WIDTH-1:0]    ram_dout_a, ram_dout_b;

  assign wr_ready = (state_q[wr_bank_q] != BANK_FULL);
  assign rd_avail = (state_q[rd_bank_q] == BANK_FULL);
  assign wr_acc   = wr_valid & wr_ready;
  assign rd_acc   = rd_req & rd_avail;
  assign rd_rel   = rd_release & rd_avail;

  // Write completion and release always target different banks, since the
  // write bank is never FULL while the read bank must be.
  always_comb begin
    state_d   = state_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_cnt_d  = wr_cnt_q;
    if (wr_acc) begin
      if (wr_cnt_q == CNT_LAST) begin
        state_d[wr_bank_q] = BANK_FULL;
        wr_cnt_d           = '0;
        wr_bank_d          = ~wr_bank_q;
      end else begin
        state_d[wr_bank_q] = BANK_FILLING;
        wr_cnt_d           = wr_cnt_q + CNT_ONE;
      end
    end
    if (rd_rel) begin
      state_d[rd_bank_q] = BANK_EMPTY;
      rd_bank_d          = ~rd_bank_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BANKS; i++) state_q[i] <= BANK_EMPTY;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_BANKS; i++) state_q[i] <= state_d[i];
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

  // RAM read register plus one output register gives the two-cycle latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend       <= 1'b0;
      rd_data_valid <= 1'b0;
      rd_data       <= '0;
    end else begin
      rd_pend       <= rd_acc;
      rd_data_valid <= rd_pend;
      if (rd_pend) rd_data <= ram_dout_b;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_BANKS; i++) bank_full[i] = (state_q[i] == BANK_FULL);
    dbg.bank1_state = state_q[1];
    dbg.bank0_state = state_q[0];
    dbg.wr_bank     = wr_bank_q;
    dbg.rd_bank     = rd_bank_q;
  end

`ifdef FMAP_BUF_ERR_EN
  logic [1:0] err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 2'b00;
    end else begin
      if (rd_req && !rd_avail) err_q[0] <= 1'b1;
      if (rd_req && (32'(rd_addr) >= 32'(FRAME_LEN))) err_q[1] <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 2'b00;
`endif

  com_dual_port_ram #(
    .WIDTH         (WIDTH),
    .ADDR_BIT      (ADDR_BIT),
    .DEPTH         (DEPTH),
    .RAM_STYLE_VAL (RAM_STYLE_VAL)
  ) u_com_dual_port_ram (
    .clk    (clk),
    .en_a   (wr_acc),
    .we_a   (wr_acc),
    .addr_a ({wr_bank_q, wr_cnt_q}),
    .di_a   (wr_data),
    .dout_a (ram_dout_a),
    .en_b   (rd_acc),
    .we_b   (1'b0),
    .addr_b ({rd_bank_q, rd_addr}),
    .di_b   ({WIDTH{1'b0}}),
    .dout_b (ram_dout_b)
  );

endmodule

// File: tb/tb_fmap_buf_ctrl.sv
// Bench for fmap_buf_ctrl with FRAME_LEN=4: directed scenarios then random
// traffic, checked against a frame-queue model and a read scoreboard.
module tb_fmap_buf_ctrl;
  import fmap_buf_pkg::*;

  localparam int W  = 4;
  localparam int AB = 10;
  localparam int FL = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [W-1:0]  wr_data = '0;
  logic          rd_req = 1'b0;
  logic [AB-2:0] rd_addr = '0;
  logic          rd_avail;
  logic          rd_data_valid;
  logic [W-1:0]  rd_data;
  logic          rd_release = 1'b0;
  logic [1:0]    bank_full;
  logic [1:0]    err;
  fmap_dbg_t     dbg;

  fmap_buf_ctrl #(
    .WIDTH(W), .ADDR_BIT(AB), .DEPTH(1024), .FRAME_LEN(FL), .RAM_STYLE_VAL("block")
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .rd_req(rd_req), .rd_addr(rd_addr), .rd_avail(rd_avail),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data), .rd_release(rd_release),
    .bank_full(bank_full), .err(err), .dbg(dbg)
  );

  // clock / reset
  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: {data, care, expected cycle}
  typedef struct packed {
    logic [W-1:0] data;
    logic         care;
    logic [31:0]  cyc;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model: completed frames in hand-over order plus the frame in progress
  logic [4*W-1:0] frames[$];
  logic [4*W-1:0] partial;
  int             part_cnt;
  logic           m_rd_bank, m_wr_bank;
  logic [1:0]     m_err;

  task automatic model_reset();
    frames.delete();
    partial   = '0;
    part_cnt  = 0;
    m_rd_bank = 1'b0;
    m_wr_bank = 1'b0;
    m_err     = 2'b00;
  endtask

  function automatic logic [1:0] exp_full();
    if (frames.size() == 0) return 2'b00;
    if (frames.size() == 1) return m_rd_bank ? 2'b10 : 2'b01;
    return 2'b11;
  endfunction

  task automatic check_outputs();
    chk("wr_ready",  wr_ready,  (frames.size() < 2));
    chk("rd_avail",  rd_avail,  (frames.size() > 0));
    chk("bank_full", bank_full, exp_full());
    chk("err",       err,       m_err);
    chk("wr_bank",   dbg.wr_bank, m_wr_bank);
    chk("rd_bank",   dbg.rd_bank, m_rd_bank);
  endtask

  // monitor: pops the scoreboard whenever the DUT presents read data
  logic [W-1:0] last_rd = '0;
  logic         mon_en  = 1'b0;

  initial begin
    exp_t e;
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (rd_data_valid) begin
        if (exp_q.size() == 0) begin
          chk("rd_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rd_latency", cyc, e.cyc);
          if (e.care) chk("rd_data", rd_data, e.data);
        end
        last_rd = rd_data;
      end else begin
        chk("rd_hold", rd_data, last_rd);
      end
    end
  end

  // driver: one cycle of stimulus; model advances with what the edge will accept
  task automatic step(input logic wv, input logic [W-1:0] wd, input logic rq,
                      input logic [AB-2:0] ra, input logic rel);
    logic avail, wrdy;
    exp_t e;
    wr_valid = wv; wr_data = wd; rd_req = rq; rd_addr = ra; rd_release = rel;
    @(negedge clk);
    check_outputs();
    avail = (frames.size() > 0);
    wrdy  = (frames.size() < 2);
`ifdef FMAP_BUF_ERR_EN
    if (rq && !avail) m_err[0] = 1'b1;
    if (rq && ra >= FL) m_err[1] = 1'b1;
`endif
    if (rq && avail) begin
      e.care = (ra < FL);
      e.data = e.care ? frames[0][ra*W +: W] : '0;
      e.cyc  = cyc + 2;
      exp_q.push_back(e);
    end
    if (rel && avail) begin
      void'(frames.pop_front());
      m_rd_bank = ~m_rd_bank;
    end
    if (wv && wrdy) begin
      partial[part_cnt*W +: W] = wd;
      part_cnt++;
      if (part_cnt == FL) begin
        frames.push_back(partial);
        part_cnt  = 0;
        m_wr_bank = ~m_wr_bank;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    wr_valid = 1'b0; rd_req = 1'b0; rd_release = 1'b0;
    rst_n   = 1'b0;
    last_rd = '0;
    model_reset();
    @(negedge clk);
    check_outputs();
    chk("rst_rd_data_valid", rd_data_valid, 1'b0);
    chk("rst_rd_data", rd_data, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [W-1:0] fill0 [4];
  logic [W-1:0] fill1 [4];

  initial begin
    fill0[0] = 4'hB; fill0[1] = 4'h8; fill0[2] = 4'hA; fill0[3] = 4'h7;
    fill1[0] = 4'h3; fill1[1] = 4'h5; fill1[2] = 4'h9; fill1[3] = 4'hC;
    model_reset();
    #1;
    do_reset();
    mon_en = 1'b1;

    // illegal read before any frame exists
    step(1'b0, '0, 1'b1, 9'd1, 1'b0);
    idle(3);

    // fill bank 0, then read every offset back-to-back
    for (int i = 0; i < 4; i++) step(1'b1, fill0[i], 1'b0, '0, 1'b0);
    idle(1);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 9'(i), 1'b0);
    idle(3);

    // fill bank 1 so both are full; a pending word is held until release
    for (int i = 0; i < 4; i++) step(1'b1, fill1[i], 1'b0, '0, 1'b0);
    step(1'b1, 4'hF, 1'b0, '0, 1'b0);
    step(1'b1, 4'hF, 1'b0, '0, 1'b1);
    // held word lands at bank 0 offset 0 while bank 1 is read out; the last
    // write completes bank 0 in the same cycle bank 1 is read and released
    step(1'b1, 4'hF, 1'b1, 9'd0, 1'b0);
    step(1'b1, 4'h1, 1'b1, 9'd1, 1'b0);
    step(1'b1, 4'h2, 1'b1, 9'd2, 1'b0);
    step(1'b1, 4'h6, 1'b1, 9'd3, 1'b1);
    idle(1);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 9'(3 - i), 1'b0);
    // out-of-frame offset is still issued; only the error flag reacts
    step(1'b0, '0, 1'b1, 9'd5, 1'b0);
    idle(3);

    // random traffic
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 3) != 0), W'($urandom_range(0, 15)),
           ($urandom_range(0, 1) == 1), 9'($urandom_range(0, FL - 1)),
           ($urandom_range(0, 7) == 0));
    idle(3);

    // reset mid-frame, then refill bank 0 from offset 0 and read it back
    step(1'b0, '0, 1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0, '0, 1'b1);
    step(1'b1, 4'hD, 1'b0, '0, 1'b0);
    step(1'b1, 4'hE, 1'b0, '0, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, fill1[3 - i], 1'b0, '0, 1'b0);
    idle(1);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 9'(i), 1'b0);
    idle(4);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end by %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/fmap_buf_ctrl.md
# fmap_buf_ctrl

Ping-pong feature-map buffer controller for the int4 CNN datapath. It splits one `com_dual_port_ram` into two equal banks. Port A is owned by the producing layer, which writes frames sequentially. Port B is owned by the consuming layer, which reads random offsets within a completed frame. Bank hand-over uses per-bank state and valid/ready handshakes, so the producer can fill one bank while the consumer reads the other.

## Interface
- `WIDTH`, 4: data word width (int4 activations).
- `ADDR_BIT`, 10: RAM address width; MSB selects the bank.
- `DEPTH`, 1024: RAM depth; must equal 2**ADDR_BIT.
- `FRAME_LEN`, 512: words per frame; 1 ≤ FRAME_LEN ≤ DEPTH/2.
- `RAM_STYLE_VAL`, "block": passed through to the RAM.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `wr_valid` in 1: producer word valid.
- `wr_ready` out 1: current write bank is not FULL.
- `wr_data` in WIDTH: producer word.
- `rd_req` in 1: consumer read request.
- `rd_addr` in ADDR_BIT-1: offset within the current read bank.
- `rd_avail` out 1: current read bank is FULL.
- `rd_data_valid` out 1: `rd_data` is valid this cycle.
- `rd_data` out WIDTH: read word.
- `rd_release` in 1: consumer is finished with the current read bank.
- `bank_full` out 2: per-bank FULL flags.
- `err` out 2: bit0 = read while not avail, bit1 = `rd_addr` ≥ FRAME_LEN (sticky).

## Operation
- Each bank has a state: EMPTY → FILLING → FULL → EMPTY.
- Pointers: `wr_bank` and `rd_bank` are 1 bit each; `wr_cnt` is ADDR_BIT-1 bits. All reset to 0.
- Write accept = `wr_valid & wr_ready`.
  - Port A is driven with `en_a = we_a = 1`, `addr_a = {wr_bank, wr_cnt}`, `di_a = wr_data`.
  - `wr_cnt` increments; the bank goes EMPTY→FILLING on its first word.
- When an accept occurs with `wr_cnt == FRAME_LEN-1`:
  - the bank goes to FULL, `wr_cnt` returns to 0, and `wr_bank` toggles.
- `wr_ready = (state[wr_bank] != FULL)`. This is combinational from registers; there is no valid→ready path.
- Read accept = `rd_req & rd_avail`.
  - Port B is driven with `en_b = 1`, `we_b = 0`, `addr_b = {rd_bank, rd_addr}`. `di_b` is tied to 0.
- `rd_req` while `!rd_avail` is dropped: port B is not enabled and no `rd_data_valid` is produced.
- `rd_release` while `rd_avail`: the bank goes FULL→EMPTY and `rd_bank` toggles. `rd_release` while `!rd_avail` is ignored.
- `rd_release` has no effect on `wr_cnt`.
- Same-cycle events:
  - `rd_req` with `rd_release`: the read is served from the current bank; the release takes effect at the next edge.
  - Writer completing bank X with reader releasing bank Y (X≠Y): both updates apply.
  - X=Y cannot occur, because a FULL bank accepts no writes.
- Reset mid-frame discards all partial and full frames. RAM contents are not cleared and are treated as invalid.

## Timing
- Reset values:
  - `wr_ready` = 1.
  - `rd_avail`, `rd_data_valid`, `bank_full`, `err` = 0.
  - `rd_data` = 0 (register).
- Write: accepted at edge N; the word is in RAM after edge N.
- Bank FULL visibility: `bank_full` and `rd_avail` rise one cycle after the last word is accepted.
- Read latency is 2 cycles: an accept in cycle N gives `rd_data_valid=1` and `rd_data` in cycle N+2. This is the RAM's registered read plus one output register.
  - Fully pipelined: one read per cycle.
  - `rd_data` holds its last value when `rd_data_valid=0`.
- Release: `rd_release` in cycle N gives a new `rd_avail` in cycle N+1. It is already 1 if the other bank is FULL.
- Throughput: continuous writes at 1 word/cycle stall only when both banks are FULL.

## Configuration
- `FMAP_BUF_ERR_EN` defined:
  - `err` bits are sticky and set on the conditions listed under Interface.
  - `rd_addr` ≥ FRAME_LEN is still issued to the RAM; only the flag is set.
  - Bits are cleared only by `rst_n`.
- `FMAP_BUF_ERR_EN` undefined: `err` is tied to 2'b00 and no error logic is synthesized.

## Structure
- Package `fmap_buf_pkg`:
  - typedef `bank_state_t` {BANK_EMPTY=2'd0, BANK_FILLING=2'd1, BANK_FULL=2'd2};
  - constant `NUM_BANKS=2`.
- One sub-module: `com_dual_port_ram` (WIDTH, ADDR_BIT, DEPTH, RAM_STYLE_VAL passed through), instance `u_com_dual_port_ram`.
- `dout_a` is unused.

## Test plan
All tests use FRAME_LEN=4 and ADDR_BIT=10.
- **Fill bank 0:** write 4'hB, 4'h8, 4'hA, 4'h7 back-to-back → `bank_full`=2'b01 one cycle after the 4th accept; `rd_avail`=1.
- **Read bank 0:** `rd_req` with `rd_addr`=0,1,2,3 consecutively → `rd_data` = B, 8, A, 7 with `rd_data_valid` two cycles after each request.
- **Both banks full:** write 8 words with no release → `wr_ready`=0 after the 8th; a 9th `wr_valid` is held and not written. Then `rd_release` → `wr_ready`=1 next cycle, `rd_bank`=1, `rd_avail`=1.
- **Simultaneous events:** the 4th write into bank 1 in the same cycle as `rd_release` of bank 0 → `bank_full`=2'b10 and `wr_bank`=0 next cycle.
- **Illegal reads:** `rd_req` when `rd_avail`=0 → no `rd_data_valid`; `err[0]`=1 with `FMAP_BUF_ERR_EN`, 0 without. `rd_addr`=5 → `err[1]`=1.
- **Reset mid-frame:** assert `rst_n`=0 after 2 writes → all outputs at reset values; the next 4 writes fill bank 0 from offset 0.
